// File: rtl/spi_flash_pkg.sv
// Shared definitions for the spi_flash register port and its read sequencer.
//
// Contents:
//   SPI_REG_CTRL / SPI_REG_DATA  register indices on the 16-register port
//   SPI_ST_*                     bit positions in the status byte
//                                {tx_hold, rx_valid, 5'b0, cs}
//   SPI_CMD_READ / _FAST_READ    flash command opcodes
//   spi_rd_state_t               read sequencer state encoding
package spi_flash_pkg;

    localparam logic [3:0] SPI_REG_CTRL = 4'd0;
    localparam logic [3:0] SPI_REG_DATA = 4'd1;

    localparam int SPI_ST_TXHOLD  = 7;
    localparam int SPI_ST_RXVALID = 6;
    localparam int SPI_ST_CS      = 0;

    localparam logic [7:0] SPI_CMD_READ      = 8'h03;
    localparam logic [7:0] SPI_CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] SPI_DUMMY         = 8'hFF;

    // Control write value that leaves CS deasserted (high).
    localparam logic [7:0] SPI_CTRL_DESEL = 8'(1 << SPI_ST_CS);

    typedef enum logic [2:0] {
        ST_DESEL,
        ST_IDLE,
        ST_SYNC,
        ST_TX,
        ST_POLL,
        ST_RD,
        ST_OUT,
        ST_END
    } spi_rd_state_t;

endpackage

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: issues a flash READ through the spi_flash register port
// and streams the returned bytes out over a valid/ready handshake.
//
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   req, req_addr, req_len     start request (sampled in IDLE), 24-bit byte
//                              address, byte count (0 = immediate done)
//   busy, done                 transfer in progress / one-cycle completion
//   out_valid, out_ready,      data byte stream
//   out_data
//   reg_addr, reg_we, reg_dbw  registered command port to spi_flash
//   reg_dbr                    spi_flash read data (registered on its side)
//
// Configuration macro: SPI_FLASH_FAST_READ_EN selects the FAST_READ opcode
// (0x0B) with one extra dummy byte in the command phase.
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [23:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [3:0]       reg_addr,
    output logic             reg_we,
    output logic [7:0]       reg_dbw,
    input  logic [7:0]       reg_dbr
);

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] CMD_BYTE  = SPI_CMD_FAST_READ;
    localparam logic [2:0] CMD_BYTES = 3'd5;
`else
    localparam logic [7:0] CMD_BYTE  = SPI_CMD_READ;
    localparam logic [2:0] CMD_BYTES = 3'd4;
`endif

    // A read presented on one edge is visible in reg_dbr two edges later.
    localparam logic [1:0] RD_LAT = 2'd2;

    spi_rd_state_t    state, state_d;
    logic [1:0]       lat;
    logic [23:0]      addr_q, addr_q_d;
    logic [LEN_W-1:0] rem, rem_d;
    logic [2:0]       tx_cnt, tx_cnt_d;
    logic [2:0]       rx_cnt, rx_cnt_d;
    logic             rx_tog, rx_tog_d;

    logic [3:0]       reg_addr_d;
    logic             reg_we_d;
    logic [7:0]       reg_dbw_d;
    logic             busy_d, done_d, out_valid_d;
    logic [7:0]       out_data_d;

    logic             rx_seen;

    // Transmit byte for a given position; past the command phase every
    // byte is a dummy that only clocks data in. With FAST_READ the slot
    // after the address is the required dummy, also 0xFF.
    function automatic logic [7:0] tx_byte(input logic [2:0] idx,
                                           input logic [23:0] a);
        logic [7:0] b;
        case (idx)
            3'd0:    b = CMD_BYTE;
            3'd1:    b = a[23:16];
            3'd2:    b = a[15:8];
            3'd3:    b = a[7:0];
            default: b = SPI_DUMMY;
        endcase
        return b;
    endfunction

    // Only samples from reads issued inside POLL are trusted; the first
    // RD_LAT cycles still show data requested before the TX write.
    assign rx_seen = (lat == RD_LAT) && (reg_dbr[SPI_ST_RXVALID] != rx_tog);

    // State register and the per-state cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_DESEL;
            lat   <= 2'd0;
        end else begin
            state <= state_d;
            if (state_d != state)
                lat <= 2'd0;
            else if (lat != RD_LAT)
                lat <= lat + 2'd1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            ST_DESEL: state_d = ST_IDLE;
            ST_IDLE:  if (req && (req_len != '0)) state_d = ST_SYNC;
            ST_SYNC:  if (lat == RD_LAT) state_d = ST_TX;
            ST_TX:    state_d = ST_POLL;
            ST_POLL:  if (rx_seen) state_d = ST_RD;
            ST_RD:    if (lat == RD_LAT)
                          state_d = (rx_cnt != CMD_BYTES) ? ST_TX : ST_OUT;
            ST_OUT:   if (out_ready)
                          state_d = (rem != '0) ? ST_TX : ST_END;
            ST_END:   if (lat == 2'd1) state_d = ST_IDLE;
            default:  state_d = ST_DESEL;
        endcase
    end

    // Output logic: next values of the registered port and datapath.
    always_comb begin
        reg_addr_d  = SPI_REG_CTRL;
        reg_we_d    = 1'b0;
        reg_dbw_d   = reg_dbw;
        busy_d      = busy;
        done_d      = 1'b0;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        addr_q_d    = addr_q;
        rem_d       = rem;
        tx_cnt_d    = tx_cnt;
        rx_cnt_d    = rx_cnt;
        rx_tog_d    = rx_tog;
        case (state)
            ST_DESEL: begin
                reg_we_d  = 1'b1;
                reg_dbw_d = SPI_CTRL_DESEL;
            end
            ST_IDLE: begin
                if (req) begin
                    if (req_len != '0) begin
                        busy_d   = 1'b1;
                        addr_q_d = req_addr;
                        rem_d    = req_len;
                        tx_cnt_d = 3'd0;
                        rx_cnt_d = 3'd0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_SYNC: begin
                if (lat == RD_LAT)
                    rx_tog_d = reg_dbr[SPI_ST_RXVALID];
            end
            ST_TX: begin
                reg_addr_d = SPI_REG_DATA;
                reg_we_d   = 1'b1;
                reg_dbw_d  = tx_byte(tx_cnt, addr_q);
                if (tx_cnt != CMD_BYTES)
                    tx_cnt_d = tx_cnt + 3'd1;
            end
            ST_POLL: begin
                if (rx_seen)
                    rx_tog_d = ~rx_tog;
            end
            ST_RD: begin
                if (lat == 2'd0)
                    reg_addr_d = SPI_REG_DATA;
                if (lat == RD_LAT) begin
                    if (rx_cnt != CMD_BYTES) begin
                        rx_cnt_d = rx_cnt + 3'd1;
                    end else begin
                        out_data_d  = reg_dbr;
                        out_valid_d = 1'b1;
                        rem_d       = rem - LEN_W'(1);
                    end
                end
            end
            ST_OUT: begin
                // No TX write here, so the SPI clock stalls under backpressure.
                if (out_ready)
                    out_valid_d = 1'b0;
            end
            ST_END: begin
                // Release CS first; done follows once spi_flash has taken it.
                if (lat == 2'd0) begin
                    reg_we_d  = 1'b1;
                    reg_dbw_d = SPI_CTRL_DESEL;
                end else begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_addr  <= SPI_REG_CTRL;
            reg_we    <= 1'b0;
            reg_dbw   <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            addr_q    <= 24'h0;
            rem       <= '0;
            tx_cnt    <= 3'd0;
            rx_cnt    <= 3'd0;
            rx_tog    <= 1'b0;
        end else begin
            reg_addr  <= reg_addr_d;
            reg_we    <= reg_we_d;
            reg_dbw   <= reg_dbw_d;
            busy      <= busy_d;
            done      <= done_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            addr_q    <= addr_q_d;
            rem       <= rem_d;
            tx_cnt    <= tx_cnt_d;
            rx_cnt    <= rx_cnt_d;
            rx_tog    <= rx_tog_d;
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Testbench for spi_flash_reader: a behavioural spi_flash register model
// with an attached flash, scoreboards for MOSI bytes and output data.
// Honours SPI_FLASH_FAST_READ_EN to select the expected command phase.
module tb_spi_flash_reader;
    import spi_flash_pkg::*;

    localparam int LEN_W = 16;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam int         CMD_N = 5;
    localparam logic [7:0] CMD_B = 8'h0B;
`else
    localparam int         CMD_N = 4;
    localparam logic [7:0] CMD_B = 8'h03;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req;
    logic [23:0]      req_addr;
    logic [LEN_W-1:0] req_len;
    logic             busy, done, out_valid, out_ready;
    logic [7:0]       out_data;
    logic [3:0]       reg_addr;
    logic             reg_we;
    logic [7:0]       reg_dbw;
    logic [7:0]       reg_dbr = 8'h00;

    always #5 clk = ~clk;

    spi_flash_reader #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req(req), .req_addr(req_addr), .req_len(req_len),
        .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .reg_addr(reg_addr), .reg_we(reg_we), .reg_dbw(reg_dbw),
        .reg_dbr(reg_dbr)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;
    int n_done   = 0;
    bit busy_seen   = 0;
    bit cs_low_seen = 0;

    logic [7:0] exp_mosi[$];
    logic [7:0] exp_data[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h012345: return 8'hA5;
            24'h012346: return 8'h5A;
            24'h012347: return 8'h3C;
            default:    return a[7:0] ^ a[15:8] ^ 8'h96;
        endcase
    endfunction

    // spi_flash register model: 16-cycle byte shift, rx_valid toggles per byte.
    logic        m_cs   = 1'b1;
    int          m_shift = 0;
    logic [7:0]  m_txb  = 8'h00;
    logic [7:0]  m_rxd  = 8'h00;
    logic        m_rxv  = 1'b0;
    int          m_idx  = 0;
    logic [23:0] m_addr = 24'h0;
    int          m_wr1  = 0;

    always @(posedge clk) begin
        reg_dbr <= (reg_addr == SPI_REG_CTRL) ?
                   {(m_shift != 0), m_rxv, 5'b0, m_cs} : m_rxd;
        if (reg_we && reg_addr == SPI_REG_CTRL) begin
            m_cs <= reg_dbw[SPI_ST_CS];
            if (reg_dbw[SPI_ST_CS]) begin
                m_idx   <= 0;
                m_shift <= 0;
            end
        end else if (reg_we && reg_addr == SPI_REG_DATA) begin
            m_cs    <= 1'b0;
            m_txb   <= reg_dbw;
            m_shift <= 16;
            m_wr1   <= m_wr1 + 1;
        end else if (m_shift == 1) begin
            if (exp_mosi.size() > 0)
                check("mosi", 32'(m_txb), 32'(exp_mosi.pop_front()));
            if (m_idx >= 1 && m_idx <= 3)
                m_addr <= {m_addr[15:0], m_txb};
            m_rxd   <= (m_idx >= CMD_N) ? flash_byte(m_addr + 24'(m_idx - CMD_N)) : 8'hFF;
            m_rxv   <= ~m_rxv;
            m_idx   <= m_idx + 1;
            m_shift <= 0;
        end else if (m_shift > 1) begin
            m_shift <= m_shift - 1;
        end
    end

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                check("out_data", 32'(out_data),
                      (exp_data.size() > 0) ? 32'(exp_data.pop_front()) : 32'hDEAD_BEEF);
                n_out++;
            end
            if (done) begin
                n_done++;
                check("done_with_valid", 32'(out_valid), 32'd0);
            end
            if (busy)  busy_seen = 1;
            if (!m_cs) cs_low_seen = 1;
        end
    end

    task automatic start_req(input logic [23:0] a, input logic [LEN_W-1:0] l);
        exp_mosi.push_back(CMD_B);
        exp_mosi.push_back(a[23:16]);
        exp_mosi.push_back(a[15:8]);
        exp_mosi.push_back(a[7:0]);
        if (CMD_N == 5) exp_mosi.push_back(8'hFF);
        for (int i = 0; i < int'(l); i++) begin
            exp_mosi.push_back(8'hFF);
            exp_data.push_back(flash_byte(a + 24'(i)));
        end
        req = 1'b1; req_addr = a; req_len = l;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0, cnt;
        d0 = n_done; cnt = 0;
        while (n_done == d0 && cnt < budget) begin
            @(posedge clk); cnt++;
        end
        #1;
        check({tag, "_done_seen"}, 32'(n_done != d0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_reg_addr"},  32'(reg_addr),  32'd0);
        check({pfx, "_reg_we"},    32'(reg_we),    32'd0);
        check({pfx, "_reg_dbw"},   32'(reg_dbw),   32'd0);
        check({pfx, "_busy"},      32'(busy),      32'd0);
        check({pfx, "_done"},      32'(done),      32'd0);
        check({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
        check({pfx, "_out_data"},  32'(out_data),  32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int o0, d0, w0, cnt, sclk_act;
        logic [7:0] held;

        rst_n = 1'b0; req = 1'b0; req_addr = 24'h0; req_len = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("desel_cs", 32'(m_cs), 32'd1);

        // Basic read: 03 01 23 45 FF FF, data A5 5A.
        o0 = n_out; d0 = n_done;
        start_req(24'h012345, 16'd2);
        check("basic_busy", 32'(busy), 32'd1);
        wait_done("basic", 2000);
        check("basic_count", 32'(n_out - o0), 32'd2);
        check("basic_done_once", 32'(n_done - d0), 32'd1);
        check("basic_cs_high", 32'(m_cs), 32'd1);
        check("basic_busy_clear", 32'(busy), 32'd0);
        check("basic_mosi_drained", 32'(exp_mosi.size()), 32'd0);

        // Zero length: done next cycle, no busy, no CS.
        busy_seen = 0; cs_low_seen = 0; d0 = n_done;
        req = 1'b1; req_addr = 24'h001000; req_len = '0;
        @(posedge clk); #1;
        req = 1'b0;
        check("zero_done", 32'(done), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("zero_done_once", 32'(n_done - d0), 32'd1);
        check("zero_busy", 32'(busy_seen), 32'd0);
        check("zero_cs", 32'(cs_low_seen), 32'd0);

        // Backpressure on byte 2.
        o0 = n_out;
        start_req(24'h012345, 16'd3);
        cnt = 0;
        while (n_out - o0 < 1 && cnt < 2000) begin @(posedge clk); cnt++; end
        #1;
        out_ready = 1'b0;
        check("bp_first_byte", 32'(n_out - o0), 32'd1);
        cnt = 0;
        while (!out_valid && cnt < 2000) begin @(posedge clk); #1; cnt++; end
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        held = out_data; w0 = m_wr1; sclk_act = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (m_shift != 0) sclk_act++;
        end
        check("bp_data_held", 32'(out_data), 32'(held));
        check("bp_data_value", 32'(out_data), 32'h5A);
        check("bp_valid_held", 32'(out_valid), 32'd1);
        check("bp_no_tx", 32'(m_wr1 - w0), 32'd0);
        check("bp_sclk_idle", 32'(sclk_act), 32'd0);
        out_ready = 1'b1;
        wait_done("bp", 2000);
        check("bp_count", 32'(n_out - o0), 32'd3);
        check("bp_data_drained", 32'(exp_data.size()), 32'd0);

        // Request while busy is ignored.
        o0 = n_out; d0 = n_done;
        start_req(24'h000100, 16'd2);
        repeat (10) @(posedge clk);
        #1;
        check("ign_busy", 32'(busy), 32'd1);
        req = 1'b1; req_addr = 24'h000010; req_len = 16'd1;
        @(posedge clk); #1;
        req = 1'b0;
        wait_done("ign", 2000);
        check("ign_count", 32'(n_out - o0), 32'd2);
        check("ign_done_once", 32'(n_done - d0), 32'd1);
        check("ign_mosi_drained", 32'(exp_mosi.size()), 32'd0);
        check("ign_busy_after", 32'(busy), 32'd0);

        // Reset during the address phase.
        start_req(24'h000200, 16'd4);
        cnt = 0;
        while (m_idx < 2 && cnt < 2000) begin @(posedge clk); cnt++; end
        #2;
        check("mid_addr_phase", 32'(m_cs), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        exp_mosi.delete();
        exp_data.delete();
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("mid_cs_released", 32'(m_cs), 32'd1);
        check("mid_busy_idle", 32'(busy), 32'd0);
        o0 = n_out;
        start_req(24'h012345, 16'd2);
        wait_done("post_rst", 2000);
        check("post_rst_count", 32'(n_out - o0), 32'd2);
        check("post_rst_cs_high", 32'(m_cs), 32'd1);

        // Single-byte read (command phase depends on the build).
        o0 = n_out;
        start_req(24'h0A0B0C, 16'd1);
        wait_done("one", 2000);
        check("one_count", 32'(n_out - o0), 32'd1);
        check("one_mosi_drained", 32'(exp_mosi.size()), 32'd0);
        check("one_data_drained", 32'(exp_data.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
